// File: rtl/mips_pkg.sv
// Shared pipeline definitions: control-word layout and specifier widths.
// Used by id_ex_reg and its bench.
package mips_pkg;

   localparam int CTRL_W     = 10;
   localparam int REG_ADDR_W = 5;

   // Control word: {aluop[3:0], regdst, alusrc, memread, memwrite, memtoreg, regwrite}
   localparam int CTRL_ALUOP_LSB = 6;
   localparam int CTRL_REGDST    = 5;
   localparam int CTRL_ALUSRC    = 4;
   localparam int CTRL_MEMREAD   = 3;
   localparam int CTRL_MEMWRITE  = 2;
   localparam int CTRL_MEMTOREG  = 1;
   localparam int CTRL_REGWRITE  = 0;

   typedef enum logic [1:0] {
      ACT_LOAD   = 2'd0,
      ACT_HOLD   = 2'd1,
      ACT_BUBBLE = 2'd2
   } idex_act_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sign_ext16.sv
// Sign-extends a 16-bit immediate to DATA_W bits by replicating bit 15.
module sign_ext16 #(
   parameter int DATA_W = 32
) (
   input  logic [15:0]       imm,
   output logic [DATA_W-1:0] ext
);

   assign ext = {{(DATA_W-16){imm[15]}}, imm};

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush, stall, bubble counting and optional
// load-use hazard detection (enabled by defining IDEX_LOAD_USE_EN).
module id_ex_reg
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [DATA_W-1:0]     id_rs_data,
   input  logic [DATA_W-1:0]     id_rt_data,
   input  logic [15:0]           id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [CTRL_W-1:0]     id_ctrl,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     ex_rs_data,
   output logic [DATA_W-1:0]     ex_rt_data,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_wreg,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic                  hazard_stall,
   output logic [15:0]           bubble_cnt
);

   logic                  valid_q,   valid_d;
   logic [DATA_W-1:0]     rs_data_q, rs_data_d;
   logic [DATA_W-1:0]     rt_data_q, rt_data_d;
   logic [DATA_W-1:0]     imm_q,     imm_d;
   logic [REG_ADDR_W-1:0] rs_q,      rs_d;
   logic [REG_ADDR_W-1:0] rt_q,      rt_d;
   logic [REG_ADDR_W-1:0] wreg_q,    wreg_d;
   logic [CTRL_W-1:0]     ctrl_q,    ctrl_d;
   logic [15:0]           cnt_q,     cnt_d;

   logic [DATA_W-1:0]     imm_ext;
   logic                  load_use;
   idex_act_e             act;

   sign_ext16 #(.DATA_W(DATA_W)) u_sext (
      .imm (id_imm),
      .ext (imm_ext)
   );

`ifdef IDEX_LOAD_USE_EN
   assign load_use = valid_q & ctrl_q[CTRL_MEMREAD] & id_valid &
                     (wreg_q != '0) & ((wreg_q == id_rs) | (wreg_q == id_rt));
`else
   assign load_use = 1'b0;
`endif
   assign hazard_stall = load_use;

   always_comb begin
      act = ACT_LOAD;
      if (flush)         act = ACT_BUBBLE;
      else if (stall)    act = ACT_HOLD;
      else if (load_use) act = ACT_BUBBLE;

      valid_d   = valid_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      wreg_d    = wreg_q;
      ctrl_d    = ctrl_q;
      cnt_d     = cnt_q;

      case (act)
         ACT_LOAD: begin
            valid_d   = id_valid;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = imm_ext;
            rs_d      = id_rs;
            rt_d      = id_rt;
            wreg_d    = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
            ctrl_d    = id_valid ? id_ctrl : '0;
         end
         ACT_BUBBLE: begin
            valid_d   = 1'b0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            wreg_d    = '0;
            ctrl_d    = '0;
            cnt_d     = sat_inc16(cnt_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         wreg_q    <= '0;
         ctrl_q    <= '0;
         cnt_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         wreg_q    <= wreg_d;
         ctrl_q    <= ctrl_d;
         cnt_q     <= cnt_d;
      end
   end

   assign ex_valid   = valid_q;
   assign ex_rs_data = rs_data_q;
   assign ex_rt_data = rt_data_q;
   assign ex_imm     = imm_q;
   assign ex_rs      = rs_q;
   assign ex_rt      = rt_q;
   assign ex_wreg    = wreg_q;
   assign ex_ctrl    = ctrl_q;
   assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg; hazard expectations follow
// IDEX_LOAD_USE_EN the same way the design build does.
module tb_id_ex_reg;
   import mips_pkg::*;

   localparam int DATA_W = 32;

`ifdef IDEX_LOAD_USE_EN
   localparam bit LU_EN = 1'b1;
`else
   localparam bit LU_EN = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  stall, flush, id_valid;
   logic [DATA_W-1:0]     id_rs_data, id_rt_data;
   logic [15:0]           id_imm;
   logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
   logic [CTRL_W-1:0]     id_ctrl;
   logic                  ex_valid;
   logic [DATA_W-1:0]     ex_rs_data, ex_rt_data, ex_imm;
   logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_wreg;
   logic [CTRL_W-1:0]     ex_ctrl;
   logic                  hazard_stall;
   logic [15:0]           bubble_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   id_ex_reg #(.DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_ctrl(id_ctrl), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data),
      .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_wreg(ex_wreg), .ex_ctrl(ex_ctrl), .hazard_stall(hazard_stall),
      .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] imm, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [9:0] ctrl,
                        input logic [31:0] rsd, input logic [31:0] rtd);
      id_valid = v; id_imm = imm; id_rs = rs; id_rt = rt; id_rd = rd;
      id_ctrl = ctrl; id_rs_data = rsd; id_rt_data = rtd;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1'b0, 16'h0, 5'd0, 5'd0, 5'd0, 10'h0, 32'h0, 32'h0);
      #12;
      check("rst_valid", {31'b0, ex_valid}, 32'h0);
      check("rst_ctrl",  {22'b0, ex_ctrl}, 32'h0);
      check("rst_cnt",   {16'b0, bubble_cnt}, 32'h0);
      rst_n = 1'b1;
      #1;

      // load, regdst=1
      drive(1'b1, 16'hFFFE, 5'd2, 5'd3, 5'd7, 10'h021, 32'h1111_1111, 32'h2222_2222);
      tick();
      check("ld_imm",    ex_imm, 32'hFFFF_FFFE);
      check("ld_wreg",   {27'b0, ex_wreg}, 32'd7);
      check("ld_valid",  {31'b0, ex_valid}, 32'h1);
      check("ld_ctrl",   {22'b0, ex_ctrl}, 32'h021);
      check("ld_rsdata", ex_rs_data, 32'h1111_1111);
      check("ld_rtdata", ex_rt_data, 32'h2222_2222);
      check("ld_rs",     {27'b0, ex_rs}, 32'd2);
      check("ld_rt",     {27'b0, ex_rt}, 32'd3);

      // regdst=0 selects rt; 0x8000 extends negative
      drive(1'b1, 16'h8000, 5'd4, 5'd9, 5'd12, 10'h050, 32'hA, 32'hB);
      tick();
      check("ld2_imm",  ex_imm, 32'hFFFF_8000);
      check("ld2_wreg", {27'b0, ex_wreg}, 32'd9);
      check("ld2_ctrl", {22'b0, ex_ctrl}, 32'h050);

      // invalid instruction: ctrl forced to 0, positive immediate
      drive(1'b0, 16'h7FFF, 5'd1, 5'd2, 5'd3, 10'h3FF, 32'hC, 32'hD);
      tick();
      check("inv_valid", {31'b0, ex_valid}, 32'h0);
      check("inv_ctrl",  {22'b0, ex_ctrl}, 32'h0);
      check("inv_imm",   ex_imm, 32'h0000_7FFF);
      check("inv_cnt",   {16'b0, bubble_cnt}, 32'h0);

      // stall holds for 3 cycles while ID changes
      drive(1'b1, 16'h1234, 5'd5, 5'd6, 5'd8, 10'h025, 32'h55, 32'h66);
      tick();
      stall = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         drive(1'b1, 16'hF000 + 16'(i), 5'(i + 10), 5'(i + 11), 5'(i + 20), 10'h3C1, 32'(i), 32'(i));
         tick();
         check("stl_imm",   ex_imm, 32'h0000_1234);
         check("stl_wreg",  {27'b0, ex_wreg}, 32'd8);
         check("stl_valid", {31'b0, ex_valid}, 32'h1);
         check("stl_ctrl",  {22'b0, ex_ctrl}, 32'h025);
         check("stl_rsd",   ex_rs_data, 32'h55);
         check("stl_cnt",   {16'b0, bubble_cnt}, 32'h0);
      end

      // flush with stall: flush wins
      flush = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0;
      check("fl_valid", {31'b0, ex_valid}, 32'h0);
      check("fl_ctrl",  {22'b0, ex_ctrl}, 32'h0);
      check("fl_wreg",  {27'b0, ex_wreg}, 32'h0);
      check("fl_rsd",   ex_rs_data, 32'h0);
      check("fl_cnt",   {16'b0, bubble_cnt}, 32'h1);

      // lw $5 in EX, add using $5 in ID
      drive(1'b1, 16'h0004, 5'd1, 5'd5, 5'd0, 10'h00B, 32'h0, 32'h0);
      tick();
      check("lw_wreg", {27'b0, ex_wreg}, 32'd5);
      drive(1'b1, 16'h0000, 5'd5, 5'd6, 5'd10, 10'h0A1, 32'h77, 32'h88);
      #1;
      check("hz_stall", {31'b0, hazard_stall}, {31'b0, LU_EN});
      tick();
      check("hz_valid", {31'b0, ex_valid}, {31'b0, ~LU_EN});
      check("hz_cnt",   {16'b0, bubble_cnt}, LU_EN ? 32'd2 : 32'd1);
      check("hz_wreg",  {27'b0, ex_wreg}, LU_EN ? 32'd0 : 32'd10);
      #1;
      check("hz_clear", {31'b0, hazard_stall}, 32'h0);

      // lw targeting $0 never stalls
      drive(1'b1, 16'h0004, 5'd1, 5'd0, 5'd0, 10'h00B, 32'h0, 32'h0);
      tick();
      drive(1'b1, 16'h0000, 5'd0, 5'd0, 5'd10, 10'h0A1, 32'h0, 32'h0);
      #1;
      check("hz0_stall", {31'b0, hazard_stall}, 32'h0);

      // asynchronous reset between edges
      drive(1'b1, 16'h00FF, 5'd1, 5'd2, 5'd3, 10'h021, 32'h9, 32'h9);
      tick();
      check("pre_rst_valid", {31'b0, ex_valid}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'b0, ex_valid}, 32'h0);
      check("arst_ctrl",  {22'b0, ex_ctrl}, 32'h0);
      check("arst_imm",   ex_imm, 32'h0);
      check("arst_cnt",   {16'b0, bubble_cnt}, 32'h0);
      #2 rst_n = 1'b1;
      #1;
      check("post_rst_valid", {31'b0, ex_valid}, 32'h0);

      // saturation of the bubble counter
      flush = 1'b1;
      for (int unsigned i = 0; i < 65534; i++) @(posedge clk);
      #1;
      check("sat_fffe", {16'b0, bubble_cnt}, 32'hFFFE);
      tick();
      check("sat_ffff", {16'b0, bubble_cnt}, 32'hFFFF);
      tick();
      check("sat_hold", {16'b0, bubble_cnt}, 32'hFFFF);
      flush = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL expose parameter: DATA_W, 32, datapath width of register operands and immediate output.
REQ-002 SHALL use a single clock and an asynchronous, active-low reset, listed first among the ports.
REQ-003 SHALL have port: clk  in  1  rising-edge clock.
REQ-004 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port: stall  in  1  external hold request; register keeps contents.
REQ-006 SHALL have port: flush  in  1  squash request; next state is a bubble.
REQ-007 SHALL have port: id_valid  in  1  decode stage holds a real instruction.
REQ-008 SHALL have port: id_rs_data, id_rt_data  in  DATA_W  register-file read values.
REQ-009 SHALL have port: id_imm  in  16  raw immediate field.
REQ-010 SHALL have port: id_rs, id_rt, id_rd  in  5  register specifiers.
REQ-011 SHALL have port: id_ctrl  in  10  {aluop[3:0], regdst, alusrc, memread, memwrite, memtoreg, regwrite}.
REQ-012 SHALL have port: ex_valid  out  1  execute-stage instruction valid.
REQ-013 SHALL have port: ex_rs_data, ex_rt_data  out  DATA_W  latched operands; ex_rt_data is D0 of the ALU operand-B mux.
REQ-014 SHALL have port: ex_imm  out  DATA_W  sign-extended immediate; D1 of the operand-B mux.
REQ-015 SHALL have port: ex_rs, ex_rt  out  5  latched source specifiers for forwarding.
REQ-016 SHALL have port: ex_wreg  out  5  destination: id_rd if regdst else id_rt.
REQ-017 SHALL have port: ex_ctrl  out  10  latched control; ex_ctrl.alusrc drives the mux select.
REQ-018 SHALL have port: hazard_stall  out  1  combinational load-use stall to PC/IF-ID.
REQ-019 SHALL have port: bubble_cnt  out  16  count of inserted bubbles.

Function
REQ-020 SHALL update once per rising clk edge; per-edge priority: flush > stall > load-use bubble > load.
REQ-021 SHALL on flush load a bubble: ex_valid=0, ex_ctrl=0, ex_wreg=0; data fields don't-care but SHALL be zeroed.
REQ-022 SHALL on stall without flush hold every output register unchanged, bubble_cnt included.
REQ-023 SHALL on load capture all id_* fields with latency exactly 1 cycle; ex_valid=id_valid; ex_ctrl forced 0 when id_valid=0.
REQ-024 SHALL sign-extend id_imm by replicating bit 15 to DATA_W bits (0x8000 -> 0xFFFF8000).
REQ-025 SHALL increment bubble_cnt on every edge a flush or load-use bubble is loaded; saturate at 0xFFFF, no wrap.
REQ-026 SHALL treat flush and stall asserted together as flush; hazard_stall ignored that edge.

Reset
REQ-027 SHALL on rst_n=0 immediately clear all outputs to 0 (ex_valid=0, ex_ctrl=0, bubble_cnt=0), independent of clk.
REQ-028 SHALL on reset deassertion mid-operation resume with a bubble in EX; no stale instruction reissued.

Configuration
REQ-029 SHALL with IDEX_LOAD_USE_EN defined drive hazard_stall=ex_valid & ex_ctrl.memread & id_valid & ex_wreg!=0 & (ex_wreg==id_rs | ex_wreg==id_rt), loading a bubble when high and not stalled/flushed.
REQ-030 SHALL with IDEX_LOAD_USE_EN undefined tie hazard_stall to 0 and omit the comparator logic.

Structure
REQ-031 SHALL place control-field bit positions, CTRL_W=10 and REG_ADDR_W=5 in shared package mips_pkg.
REQ-032 SHALL use one sub-module, sign_ext16, for immediate extension; all else in id_ex_reg.

Verification
REQ-033 SHALL show load: id_valid=1, id_imm=0xFFFE, regdst=1, id_rd=7 -> next cycle ex_imm=0xFFFFFFFE, ex_wreg=7, ex_valid=1.
REQ-034 SHALL show stall=1 for 3 cycles with changing id_* -> all ex_* and bubble_cnt constant.
REQ-035 SHALL show flush=1 and stall=1 same edge -> ex_valid=0, ex_ctrl=0, bubble_cnt +1.
REQ-036 SHALL show (macro on) EX lw wreg=5, ID add rs=5 -> hazard_stall=1, next ex_valid=0; with wreg=0 -> hazard_stall=0.
REQ-037 SHALL show rst_n pulled low between edges with ex_valid=1 -> outputs 0 before next edge; bubble_cnt preset near 0xFFFF saturates at 0xFFFF.
